// File: rtl/fifo_pkg.sv
// Shared constants and types for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } read_mode_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                       clock,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and selectable first-word-fall-through read mode.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            write,
  input  logic                            read,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam read_mode_e MODE = (FWFT != 0) ? FWFT_ON : FWFT_OFF;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_sync_param: AFULL_THRESH must not exceed DEPTH");
  end
  if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
    $error("fifo_sync_param: AEMPTY_THRESH must be below DEPTH");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, almost_full_q, almost_empty_q;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_ok_s, wr_ok_s, mem_we_s, head_is_input_s;
  logic [PW-1:0]         rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // FWFT reads the word that will be at the head after this edge; standard mode reads the current head.
  assign rd_addr_s = (MODE == FWFT_ON) ? rd_ptr_d : rd_ptr_q;
  assign mem_we_s  = wr_ok_s && !reset;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clock   (clock),
    .we_i    (mem_we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Acceptance, pointer/count next state, error pulses and next read data.
  always_comb begin
    rd_ok_s     = read && !empty_q;
    wr_ok_s     = write && (!full_q || rd_ok_s);
    wr_ptr_d    = wr_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d    = rd_ok_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    overflow_d  = write && !wr_ok_s;
    underflow_d = read && !rd_ok_s;
    count_d     = count_q;
    if (wr_ok_s && !rd_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok_s && rd_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    // No older word survives this edge, so the new head is the word being written now.
    head_is_input_s = (count_q == {{(CW-1){1'b0}}, rd_ok_s});
    data_out_d      = data_out_q;
    case (MODE)
      FWFT_ON: begin
        if (count_d != '0) begin
          data_out_d = head_is_input_s ? data_in : rd_data_s;
        end else begin
          data_out_d = data_out_q;
        end
      end
      default: begin
        data_out_d = rd_ok_s ? rd_data_s : data_out_q;
      end
    endcase
  end

  // State registers; flags are registered from the next count so they move with count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      data_out_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= (count_d == '0);
      full_q         <= (count_d == DEPTH_C);
      almost_empty_q <= (count_d <= AEMPTY_C);
      almost_full_q  <= (count_d >= AFULL_C);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      data_out_q     <= data_out_d;
    end
  end

  assign data_out     = data_out_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-read and an FWFT instance share stimulus
// and are compared each cycle against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, afull0, aempty0, ovf0, unf0;
  logic          full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [CW-1:0] count0, count1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_dout0 = '0;
  logic [DW-1:0] exp_dout1 = '0;
  logic          exp_ovf = 1'b0;
  logic          exp_unf = 1'b0;

  always #5 clock = ~clock;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_dut0 (
    .clock(clock), .reset(reset), .data_in(data_in), .write(write), .read(read),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(afull0),
    .almost_empty(aempty0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_dut1 (
    .clock(clock), .reset(reset), .data_in(data_in), .write(write), .read(read),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(afull1),
    .almost_empty(aempty1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic w, input logic r, input logic [DW-1:0] d, input logic rst);
    bit rd_ok, wr_ok;
    if (rst) begin
      mq.delete();
      exp_dout0 = '0;
      exp_dout1 = '0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      rd_ok = r && (mq.size() > 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_dout0 = mq.pop_front();
      if (wr_ok) mq.push_back(d);
      exp_ovf = w && !wr_ok;
      exp_unf = r && !rd_ok;
      if (mq.size() > 0) exp_dout1 = mq[0];
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = mq.size();
    check("count0",  32'(count0),  32'(sz));
    check("count1",  32'(count1),  32'(sz));
    check("empty0",  32'(empty0),  32'(sz == 0));
    check("empty1",  32'(empty1),  32'(sz == 0));
    check("full0",   32'(full0),   32'(sz == DEPTH));
    check("full1",   32'(full1),   32'(sz == DEPTH));
    check("afull0",  32'(afull0),  32'(sz >= DEPTH - 2));
    check("afull1",  32'(afull1),  32'(sz >= DEPTH - 2));
    check("aempty0", 32'(aempty0), 32'(sz <= 2));
    check("aempty1", 32'(aempty1), 32'(sz <= 2));
    check("ovf0",    32'(ovf0),    32'(exp_ovf));
    check("ovf1",    32'(ovf1),    32'(exp_ovf));
    check("unf0",    32'(unf0),    32'(exp_unf));
    check("unf1",    32'(unf1),    32'(exp_unf));
    check("dout_std",  32'(dout0), 32'(exp_dout0));
    check("dout_fwft", 32'(dout1), 32'(exp_dout1));
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rst);
    write   = w;
    read    = r;
    data_in = d;
    reset   = rst;
    @(posedge clock);
    model_update(w, r, d, rst);
    #1;
    compare_all();
    write = 1'b0;
    read  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int wprob, rprob;

    // Reset
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Fill with 0x01..0x10; almost_full rises at 14, full at 16
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    check("fill_full", 32'(full0), 32'd1);

    // Overflow when full, then drain in order
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_pulse", 32'(ovf0), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Underflow from empty; then write+read together while empty
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    check("wr_rd_empty_cnt", 32'(count0), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Fill, then sustained read+write at full across the pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h77, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // FWFT first-word fall-through with no read issued
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    check("fwft_first", 32'(dout1), 32'h3C);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Reset mid-operation with write asserted
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Randomised traffic with phases biased towards full and empty
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0:       begin wprob = 80; rprob = 30; end
        1:       begin wprob = 30; rprob = 80; end
        default: begin wprob = 50; rprob = 50; end
      endcase
      step(32'($urandom_range(0, 99)) < wprob,
           32'($urandom_range(0, 99)) < rprob,
           8'($urandom),
           $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
